// File: rtl/pc_branch_seq.sv
// Fetch-PC sequencer with delayed-redirect handling for a delay-slot pipeline.
// A redirect that meets a fetch stall is parked in PEND until fetch is free.
module pc_branch_seq #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             excFlush,
    input  logic [31:0]      excPC,
    input  logic             brValidD,
    input  logic             isBranchNeededD,
    input  logic             isJumpD,
    input  logic             isJumpToRegD,
    input  logic [31:0]      brTargetD,
    input  logic [31:0]      jTargetD,
    input  logic [31:0]      regTargetD,
    output logic [31:0]      pcF,
    output logic [31:0]      pcD,
    output logic [31:0]      pcPlus8D,
    output logic             isInDelaySlotD,
    output logic             redirectPending,
    output logic [CNT_W-1:0] brCnt,
    output logic [CNT_W-1:0] takenCnt
);

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      pc_f_q, pc_f_d;
    logic [31:0]      pc_d_q, pc_d_d;
    logic             in_ds_q, in_ds_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic             redirect_pending_q, redirect_pending_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic        taken_d;
    logic [31:0] sel_tgt;

    always_comb begin
        taken_d = brValidD & ~stallD & (isJumpD | isJumpToRegD | isBranchNeededD);
        if (isJumpToRegD)
            sel_tgt = regTargetD;
        else if (isJumpD)
            sel_tgt = jTargetD;
        else
            sel_tgt = brTargetD;
    end

    always_comb begin
        state_d     = state_q;
        pend_tgt_d  = pend_tgt_q;
        pc_f_d      = pc_f_q;
        pc_d_d      = pc_d_q;
        in_ds_d     = in_ds_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;

        if (excFlush) begin
            // Exception wins over everything and drops any parked redirect.
            pc_f_d     = excPC;
            state_d    = RUN;
            pend_tgt_d = 32'h0;
        end else if (state_q == PEND) begin
            if (!stallF) begin
                pc_f_d  = pend_tgt_q;
                state_d = RUN;
            end
        end else if (taken_d) begin
            if (stallF) begin
                pend_tgt_d = sel_tgt;
                state_d    = PEND;
            end else begin
                pc_f_d = sel_tgt;
            end
        end else if (!stallF) begin
            pc_f_d = pc_f_q + 32'd4;
        end

        if (excFlush) begin
            pc_d_d  = excPC;
            in_ds_d = 1'b0;
        end else if (!stallD) begin
            pc_d_d  = pc_f_q;
            in_ds_d = brValidD;
        end

        if (brValidD && !stallD && !excFlush && br_cnt_q != '1)
            br_cnt_d = br_cnt_q + CNT_ONE;
        if (taken_d && !excFlush && taken_cnt_q != '1)
            taken_cnt_d = taken_cnt_q + CNT_ONE;

        redirect_pending_d = (state_d == PEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= RUN;
            pend_tgt_q         <= 32'h0;
            pc_f_q             <= RESET_PC;
            pc_d_q             <= RESET_PC;
            in_ds_q            <= 1'b0;
            redirect_pending_q <= 1'b0;
            br_cnt_q           <= '0;
            taken_cnt_q        <= '0;
        end else begin
            state_q            <= state_d;
            pend_tgt_q         <= pend_tgt_d;
            pc_f_q             <= pc_f_d;
            pc_d_q             <= pc_d_d;
            in_ds_q            <= in_ds_d;
            redirect_pending_q <= redirect_pending_d;
            br_cnt_q           <= br_cnt_d;
            taken_cnt_q        <= taken_cnt_d;
        end
    end

    assign pcF             = pc_f_q;
    assign pcD             = pc_d_q;
    assign pcPlus8D        = pc_d_q + 32'd8;
    assign isInDelaySlotD  = in_ds_q;
    assign redirectPending = redirect_pending_q;
    assign brCnt           = br_cnt_q;
    assign takenCnt        = taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_seq.sv
// Directed bench for pc_branch_seq: each cycle's expected outputs are queued
// before the edge and compared after it, plus fixed-value spot checks.
module tb_pc_branch_seq;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst, stallF, stallD, excFlush;
    logic        brValidD, isBranchNeededD, isJumpD, isJumpToRegD;
    logic [31:0] excPC, brTargetD, jTargetD, regTargetD;
    logic [31:0] pcF, pcD, pcPlus8D;
    logic        isInDelaySlotD, redirectPending;
    logic [3:0]  brCnt, takenCnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] pcf;
        logic [31:0] pcd;
        logic        ds;
        logic        pend;
        logic [31:0] tgt;
        logic [3:0]  br;
        logic [3:0]  tk;
    } exp_t;

    exp_t sbq[$];

    logic [31:0] m_pcf, m_pcd, m_tgt;
    logic        m_ds, m_pend;
    logic [3:0]  m_br, m_tk;

    always #5 clk = ~clk;

    pc_branch_seq #(.RESET_PC(RST_PC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .excFlush(excFlush), .excPC(excPC), .brValidD(brValidD),
        .isBranchNeededD(isBranchNeededD), .isJumpD(isJumpD),
        .isJumpToRegD(isJumpToRegD), .brTargetD(brTargetD),
        .jTargetD(jTargetD), .regTargetD(regTargetD), .pcF(pcF), .pcD(pcD),
        .pcPlus8D(pcPlus8D), .isInDelaySlotD(isInDelaySlotD),
        .redirectPending(redirectPending), .brCnt(brCnt), .takenCnt(takenCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pcF"}, pcF, m_pcf);
        chk({tag, ".pcD"}, pcD, m_pcd);
        chk({tag, ".pcPlus8D"}, pcPlus8D, m_pcd + 32'd8);
        chk({tag, ".inDS"}, {31'b0, isInDelaySlotD}, {31'b0, m_ds});
        chk({tag, ".pend"}, {31'b0, redirectPending}, {31'b0, m_pend});
        chk({tag, ".brCnt"}, {28'b0, brCnt}, {28'b0, m_br});
        chk({tag, ".takenCnt"}, {28'b0, takenCnt}, {28'b0, m_tk});
    endtask

    task automatic model_reset();
        m_pcf = RST_PC; m_pcd = RST_PC; m_tgt = 32'h0;
        m_ds = 1'b0; m_pend = 1'b0; m_br = 4'd0; m_tk = 4'd0;
    endtask

    task automatic idle();
        stallF = 0; stallD = 0; excFlush = 0; brValidD = 0;
        isBranchNeededD = 0; isJumpD = 0; isJumpToRegD = 0;
    endtask

    // Predict next-edge outputs, queue them, clock, then compare.
    task automatic step(input string tag);
        exp_t        e;
        logic        tkn;
        logic [31:0] sel;
        tkn = brValidD & ~stallD & (isJumpD | isJumpToRegD | isBranchNeededD);
        sel = isJumpToRegD ? regTargetD : (isJumpD ? jTargetD : brTargetD);
        e.tag = tag; e.pcf = m_pcf; e.pcd = m_pcd; e.ds = m_ds;
        e.pend = m_pend; e.tgt = m_tgt; e.br = m_br; e.tk = m_tk;
        if (excFlush) begin
            e.pcf = excPC; e.pend = 1'b0; e.tgt = 32'h0;
        end else if (m_pend) begin
            if (!stallF) begin e.pcf = m_tgt; e.pend = 1'b0; end
        end else if (tkn && stallF) begin
            e.pend = 1'b1; e.tgt = sel;
        end else if (tkn) begin
            e.pcf = sel;
        end else if (!stallF) begin
            e.pcf = m_pcf + 32'd4;
        end
        if (excFlush) begin
            e.pcd = excPC; e.ds = 1'b0;
        end else if (!stallD) begin
            e.pcd = m_pcf; e.ds = brValidD;
        end
        if (brValidD && !stallD && !excFlush && m_br != 4'hF) e.br = m_br + 4'd1;
        if (tkn && !excFlush && m_tk != 4'hF) e.tk = m_tk + 4'd1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        m_pcf = e.pcf; m_pcd = e.pcd; m_ds = e.ds; m_pend = e.pend;
        m_tgt = e.tgt; m_br = e.br; m_tk = e.tk;
        chk_all(e.tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all(tag);
    endtask

    logic [31:0] pc_before;

    initial begin
        rst = 1'b0;
        idle();
        excPC = 32'h0; brTargetD = 32'h0; jTargetD = 32'h0; regTargetD = 32'h0;
        model_reset();
        #2;
        do_reset("rst0");
        chk("rst0.pcF_const", pcF, 32'hBFC00000);

        // Free-running fetch after reset.
        step("run1"); chk("run1.pcF_const", pcF, 32'hBFC00004);
        step("run2"); chk("run2.pcF_const", pcF, 32'hBFC00008);
        step("run3"); chk("run3.pcF_const", pcF, 32'hBFC0000C);
        chk("run3.pcPlus8D_const", pcPlus8D, 32'hBFC00010);

        // Taken BEQ with fetch at BFC00008.
        do_reset("rst1");
        step("pre1");
        step("pre2");
        chk("beq.pcF_before", pcF, 32'hBFC00008);
        brValidD = 1; isBranchNeededD = 1; brTargetD = 32'hBFC00100;
        step("beq");
        chk("beq.pcF_const", pcF, 32'hBFC00100);
        chk("beq.ds_const", {31'b0, isInDelaySlotD}, 32'd1);
        chk("beq.br_const", {28'b0, brCnt}, 32'd1);
        chk("beq.tk_const", {28'b0, takenCnt}, 32'd1);
        idle();
        step("beq_after");

        // JR parked behind a 3-cycle fetch stall; a second jump in PEND is ignored.
        pc_before = m_pcf;
        brValidD = 1; isJumpToRegD = 1; regTargetD = 32'h80001000; stallF = 1;
        step("jr_s1");
        idle(); stallF = 1; brValidD = 1; isJumpD = 1; jTargetD = 32'hDEAD0000;
        step("jr_s2");
        idle(); stallF = 1;
        step("jr_s3");
        chk("jr.pend_const", {31'b0, redirectPending}, 32'd1);
        chk("jr.pcF_held", pcF, pc_before);
        idle();
        step("jr_go");
        chk("jr.pcF_const", pcF, 32'h80001000);
        chk("jr.pend_clear", {31'b0, redirectPending}, 32'd0);
        step("jr_next");

        // Branch held in decode, then resolved not-taken.
        brValidD = 1; isBranchNeededD = 0; stallD = 1; stallF = 1;
        step("nt_s1");
        step("nt_s2");
        pc_before = pcF;
        stallD = 0; stallF = 0;
        step("nt_go");
        chk("nt.pcF_plus4", pcF, pc_before + 32'd4);
        idle();
        brValidD = 1; isBranchNeededD = 1; stallD = 1; brTargetD = 32'h12340000;
        step("stalled_taken_no_redirect");
        idle();

        // Exception flush racing a new jump while a redirect is parked.
        brValidD = 1; isJumpToRegD = 1; regTargetD = 32'h80002000; stallF = 1;
        step("exc_pend");
        idle();
        excFlush = 1; excPC = 32'hBFC00380; stallF = 1;
        brValidD = 1; isJumpD = 1; jTargetD = 32'h80003000;
        step("exc_flush");
        chk("exc.pcF_const", pcF, 32'hBFC00380);
        chk("exc.ds_const", {31'b0, isInDelaySlotD}, 32'd0);
        idle();
        step("exc_r1");
        step("exc_r2");
        chk("exc.pcF_r2", pcF, 32'hBFC00388);

        // Reset while a redirect is parked.
        brValidD = 1; isJumpToRegD = 1; regTargetD = 32'h80004000; stallF = 1;
        step("rst_pend");
        idle();
        do_reset("rst_mid_pend");
        step("rst_mid_after");
        chk("rst_mid.pcF_const", pcF, 32'hBFC00004);

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            brValidD = 1; isBranchNeededD = 1; brTargetD = 32'hA0000000 + 32'(i * 16);
            step($sformatf("sat%0d", i));
        end
        chk("sat.br_const", {28'b0, brCnt}, 32'd15);
        chk("sat.tk_const", {28'b0, takenCnt}, 32'd15);
        idle();
        step("sat_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
